lsu: RTL and testbench
======================

# lsu

Load/store unit between the MEM pipeline stage and the word-organised data RAM. The RAM has a single write enable, a shared read/write address, and word-wide data only. This block turns byte, halfword and word loads and stores into RAM cycles. Sub-word stores become read-modify-write sequences, and sub-word loads are lane-selected and sign- or zero-extended. A multi-cycle FSM drives the RAM and stalls the pipeline while an access is in flight.

## Interface
Parameters:
- ADDR_W, 32, byte-address width
- DATA_W, 32, data width (fixed 32; lane logic assumes 4 bytes)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  access request from MEM stage
- req_ready  out  1  high only in IDLE and rst low; accept = req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  one-cycle pulse, access complete
- resp_rdata  out  DATA_W  extended load data; 0 for stores
- resp_err  out  1  misaligned-access flag (see Configuration)
- stall  out  1  high whenever state != IDLE
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address, always {addr[31:2],2'b00}
- ram_wdata  out  DATA_W  RAM write word
- ram_rdata  in  DATA_W  RAM read word, combinational from ram_addr when ram_we=0

## Operation
- FSM states: IDLE, LOAD, MRD (merge read), WRITE, DONE.
- On accept, register we, size, unsigned, addr and wdata.
- Transitions out of IDLE on accept:
  - load → LOAD
  - word store → WRITE
  - byte or half store → MRD
- LOAD: ram_we=0; ram_rdata lane-selected, extended, and registered into resp_rdata; → DONE.
- MRD: ram_we=0; target lanes of ram_rdata replaced with store data; merged word registered as write word; → WRITE.
- WRITE: ram_we=1, ram_wdata = write word; → DONE. ram_rdata is not sampled here, because the RAM returns 0 while writing.
- DONE: resp_valid=1 → IDLE.
- Lanes are little-endian:
  - byte k = bits [8k+7:8k], with k = addr[1:0]
  - half h = bits [16h+15:16h], with h = addr[1]
- Sign extension copies the selected lane's MSB into the upper bits; unsigned loads zero-fill.
- ram_addr = 0 and ram_wdata = 0 in IDLE.
- ram_we = (state==WRITE) & ~rst.

## Timing
- Reset values: req_ready 0 while rst high, then 1; all other outputs 0; state IDLE.
- rst high in any state: next edge → IDLE, in-flight access discarded, no resp_valid. A WRITE cycle coinciding with rst does not write.
- Latency from accept edge to resp_valid high, counted in cycles after the accept edge:
  - load: 2 (LOAD, DONE)
  - word store: 2 (WRITE, DONE)
  - sub-word store: 3 (MRD, WRITE, DONE)
- Request inputs are ignored outside IDLE. The MEM stage holds them until accepted.
- No back-to-back accepts: DONE always returns to IDLE before the next accept.
- resp_rdata and resp_err are held until the next accept.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: a half access with addr[0]=1, or a word access with addr[1:0]≠0, goes IDLE → DONE.
  - No RAM cycle is issued.
  - resp_err=1 and resp_rdata=0 in DONE.
  - Latency is 1.
- LSU_MISALIGN_TRAP_EN undefined:
  - Half accesses ignore addr[0]; word accesses ignore addr[1:0].
  - Access proceeds as aligned.
  - resp_err is tied 0.

## Test plan
- Word store 0xDEADBEEF @0x10, then word load @0x10 → RAM[4]=0xDEADBEEF written in WRITE; load resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
- RAM[4]=0x11223344; byte store 0xAA @0x11 → MRD, WRITE, DONE sequence; RAM[4]=0x1122AA44; resp_valid 3 cycles after accept.
- RAM[4]=0x000080FF:
  - signed byte load @0x10 → 0xFFFFFFFF
  - signed byte load @0x11 → 0xFFFFFF80
  - unsigned byte load @0x11 → 0x00000080
- RAM[4]=0x8001xxxx; half load @0x12, signed → 0xFFFF8001; unsigned → 0x00008001.
- Misaligned word load @0x13:
  - with LSU_MISALIGN_TRAP_EN: resp_err=1, resp_rdata=0, ram_we never 1, resp_valid 1 cycle after accept
  - without the macro: reads RAM[4], resp_err=0
- Byte store accepted, rst asserted during WRITE cycle → RAM unchanged, no resp_valid, state IDLE, req_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: turns byte/half/word accesses into cycles on a word-wide RAM.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses complete with resp_err).
`timescale 1ns/1ps
module lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, MRD, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic              accept, misalign;
  logic [DATA_W-1:0] byte_shift, half_shift, load_ext, merged;

  assign accept = req_valid & req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'b01) & req_addr[0]) | (req_size[1] & (|req_addr[1:0]));
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misalign)     state_d = DONE;
          else if (!req_we) state_d = LOAD;
          else if (req_size[1]) state_d = WRITE;
          else              state_d = MRD;
        end
      end
      LOAD:    state_d = DONE;
      MRD:     state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE) & ~rst;
    stall      = (state_q != IDLE);
    resp_valid = (state_q == DONE);
    ram_we     = (state_q == WRITE) & ~rst;
    ram_addr   = '0;
    ram_wdata  = '0;
    if (state_q != IDLE) ram_addr = {addr_q[ADDR_W-1:2], 2'b00};
    if (state_q == WRITE) ram_wdata = wdata_q;
  end

  // Half lanes are chosen by addr[1] only, so a misaligned half reads as aligned.
  assign byte_shift = ram_rdata >> {addr_q[1:0], 3'b000};
  assign half_shift = ram_rdata >> {addr_q[1], 4'b0000};

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{(DATA_W-8){~uns_q & byte_shift[7]}}, byte_shift[7:0]};
      2'b01:   load_ext = {{(DATA_W-16){~uns_q & half_shift[15]}}, half_shift[15:0]};
      default: load_ext = ram_rdata;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic lane_en;
      assign lane_en = (size_q == 2'b00) ? (addr_q[1:0] == 2'(gi)) : (addr_q[1] == 1'(gi / 2));
      assign merged[8*gi +: 8] = lane_en
        ? ((size_q == 2'b00) ? wdata_q[7:0] : wdata_q[8*(gi % 2) +: 8])
        : ram_rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
        err_q   <= misalign;
      end
      if (state_q == LOAD) rdata_q <= load_ext;
      // The merged word replaces the raw store data for the following WRITE.
      if (state_q == MRD)  wdata_q <= merged;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, reset-abort sequence and random accesses vs a byte-level model.
`timescale 1ns/1ps
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, stall, ram_we;
  logic [31:0] resp_rdata, ram_addr, ram_wdata, ram_rdata;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] mem [0:63];
  logic [7:0]  rb  [0:255];

  always #5 clk = ~clk;

  lsu #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Word RAM: combinational read, returns 0 during a write cycle.
  assign ram_rdata = ram_we ? 32'h0 : mem[ram_addr[7:2]];
  always @(posedge clk) if (ram_we) mem[ram_addr[7:2]] <= ram_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic preload(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) rb[4*w+i] = v[8*i +: 8];
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic ref_misaligned(input logic [1:0] size, input logic [7:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    return (addr % nbytes(size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns, input logic [7:0] addr);
    int n = nbytes(size);
    int ea = (int'(addr) / n) * n;
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(rb[ea+i]) << (8*i));
    if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [7:0] addr, input logic [31:0] wd);
    int n = nbytes(size);
    int ea = (int'(addr) / n) * n;
    for (int i = 0; i < n; i++) rb[ea+i] = 8'((wd >> (8*i)) & 32'hFF);
  endtask

  // Called at a negedge; returns at the negedge where resp_valid was seen.
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic [31:0] rdata, output logic err,
                           output int lat, output int nwr, output logic stl);
    int k;
    lat = -1; nwr = 0; stl = 1'b0; rdata = 32'h0; err = 1'b0;
    for (k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    if (!req_ready) begin
      check("ready_timeout", {31'h0, req_ready}, 32'h1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    for (k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        stl = stall;
        req_valid = 1'b0;
        req_wdata = $urandom;
      end
      if (ram_we) nwr++;
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  typedef struct {
    logic        pre_en;
    logic [31:0] pre_val;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [31:0] rd, erd;
    logic er, ee, stl;
    int lat, nwr, elat;
    string tag;

    // Directed vectors; word 4 (byte address 0x10) is the target of every entry.
    vt[0] = '{1'b0, 32'h0,        1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 32'hDEADBEEF};
    vt[1] = '{1'b0, 32'h0,        1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 32'hDEADBEEF};
    vt[2] = '{1'b1, 32'h11223344, 1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, 32'h0,        1'b0, 3, 32'h1122AA44};
    vt[3] = '{1'b1, 32'h000080FF, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 32'h000080FF};
    vt[4] = '{1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 32'h11, 32'h0,        32'hFFFFFF80, 1'b0, 2, 32'h000080FF};
    vt[5] = '{1'b0, 32'h0,        1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        32'h00000080, 1'b0, 2, 32'h000080FF};
    vt[6] = '{1'b1, 32'h80011234, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'hFFFF8001, 1'b0, 2, 32'h80011234};
    vt[7] = '{1'b0, 32'h0,        1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'h00008001, 1'b0, 2, 32'h80011234};
    vt[8] = '{1'b1, 32'h11223344, 1'b1, 2'b01, 1'b0, 32'h12, 32'h7777BEEF, 32'h0,        1'b0, 3, 32'hBEEF3344};
`ifdef LSU_MISALIGN_TRAP_EN
    vt[9] = '{1'b1, 32'hCAFEF00D, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0,        32'h0,        1'b1, 1, 32'hCAFEF00D};
`else
    vt[9] = '{1'b1, 32'hCAFEF00D, 1'b0, 2'b10, 1'b0, 32'h13, 32'h0,        32'hCAFEF00D, 1'b0, 2, 32'hCAFEF00D};
`endif

    for (int w = 0; w < 64; w++) preload(w, 32'h0);
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_ram_we", {31'h0, ram_we}, 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'h0, resp_err}, 32'h0);
    rst = 1'b0;
    #1 check("post_rst_ready", {31'h0, req_ready}, 32'h1);
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      tag = $sformatf("vec%0d", i);
      if (vt[i].pre_en) preload(4, vt[i].pre_val);
      do_access(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata, rd, er, lat, nwr, stl);
      $display("%s we=%0d size=%0d uns=%0d addr=%h rdata=%h err=%0d lat=%0d", tag,
               vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, rd, er, lat);
      check({tag, "_rdata"}, rd, vt[i].exp_rdata);
      check({tag, "_err"}, {31'h0, er}, {31'h0, vt[i].exp_err});
      check({tag, "_lat"}, 32'(lat), 32'(vt[i].exp_lat));
      check({tag, "_writes"}, 32'(nwr), (vt[i].we && !vt[i].exp_err) ? 32'd1 : 32'd0);
      check({tag, "_stall"}, {31'h0, stl}, 32'h1);
      @(negedge clk);
      check({tag, "_mem"}, mem[4], vt[i].exp_mem);
      check({tag, "_pulse"}, {31'h0, resp_valid}, 32'h0);
      check({tag, "_hold"}, resp_rdata, vt[i].exp_rdata);
    end

    // Sub-word store aborted by reset in its WRITE cycle.
    preload(5, 32'h55667788);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h99;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_write", {31'h0, ram_we}, 32'h1);
    rst = 1'b1;
    #1 check("abort_we_gated", {31'h0, ram_we}, 32'h0);
    @(negedge clk);
    check("abort_no_resp", {31'h0, resp_valid}, 32'h0);
    check("abort_idle", {31'h0, stall}, 32'h0);
    check("abort_ready_low", {31'h0, req_ready}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'h0, req_ready}, 32'h1);
    check("abort_no_resp2", {31'h0, resp_valid}, 32'h0);
    check("abort_mem", mem[5], 32'h55667788);
    $display("abort sequence mem[5]=%h ready=%0d", mem[5], req_ready);

    // Random accesses against the byte-array model.
    for (int w = 0; w < 64; w++) preload(w, $urandom);
    for (int t = 0; t < 150; t++) begin
      logic        we, uns;
      logic [1:0]  size;
      logic [7:0]  a;
      logic [31:0] wd;
      we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); a = 8'($urandom_range(0, 255)); wd = $urandom;
      ee = ref_misaligned(size, a);
      erd = (we || ee) ? 32'h0 : ref_load(size, uns, a);
      elat = ee ? 1 : (!we || size[1]) ? 2 : 3;
      do_access(we, size, uns, {24'h0, a}, wd, rd, er, lat, nwr, stl);
      $display("rand%0d we=%0d size=%0d uns=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
               t, we, size, uns, a, wd, rd, er, lat);
      tag = $sformatf("rand%0d", t);
      check({tag, "_rdata"}, rd, erd);
      check({tag, "_err"}, {31'h0, er}, {31'h0, ee});
      check({tag, "_lat"}, 32'(lat), 32'(elat));
      if (we && !ee) ref_store(size, a, wd);
      @(negedge clk);
      if (we) check({tag, "_mem"}, mem[a[7:2]],
                    {rb[{a[7:2], 2'd3}], rb[{a[7:2], 2'd2}], rb[{a[7:2], 2'd1}], rb[{a[7:2], 2'd0}]});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
